// File: rtl/sccb_clk_gen.sv
`default_nettype none
// ============================================================================
// sccb_clk_gen : runtime-programmable SCCB clock and phase-strobe generator
// Revision     : 1.0
// ============================================================================
module sccb_clk_gen #(
   parameter int CLK_FREQ      = 10_000_000,
   parameter int SCCB_CLK_FREQ = 100_000,
   parameter int DIV_WIDTH     = 16,
   parameter int DIV_MIN       = 3
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div_in,
   input  logic                 div_load,
   output logic                 sccb_clk,
   output logic                 fall_pulse,
   output logic                 rise_pulse,
   output logic                 mid_low_pulse,
   output logic                 mid_high_pulse,
   output logic                 stop_pulse,
   output logic                 busy,
   output logic [DIV_WIDTH-1:0] div_active
);

   localparam int c_def_raw = (CLK_FREQ / SCCB_CLK_FREQ) / 2 - 1;
   localparam int c_def_int = (c_def_raw < DIV_MIN) ? DIV_MIN : c_def_raw;
   localparam logic [DIV_WIDTH-1:0] c_def     = DIV_WIDTH'(c_def_int);
   localparam logic [DIV_WIDTH-1:0] c_div_min = DIV_WIDTH'(DIV_MIN);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_LOW  = 2'd1;
   localparam logic [1:0] c_HIGH = 2'd2;

   logic [1:0]           r_state;
   logic [DIV_WIDTH-1:0] r_count;
   logic [DIV_WIDTH-1:0] r_div_active;
   logic [DIV_WIDTH-1:0] r_pending;
   logic                 r_pending_valid;
   logic                 r_sccb_clk;
   logic                 r_fall;
   logic                 r_rise;
   logic                 r_mid_low;
   logic                 r_mid_high;
   logic                 r_stop;

   logic [DIV_WIDTH-1:0] w_mid;
   logic [DIV_WIDTH-1:0] w_load_val;
   logic                 w_end;
   logic                 w_boundary;

   // (D+1)/2 - 1 rewritten as (D>>1) minus one for even D, avoiding a D+1 overflow bit
   assign w_mid      = (r_div_active >> 1) - {{(DIV_WIDTH-1){1'b0}}, ~r_div_active[0]};
   assign w_load_val = (div_in < c_div_min) ? c_div_min : div_in;
   assign w_end      = (r_count == r_div_active);
   assign w_boundary = (r_state == c_IDLE) || ((r_state == c_HIGH) && w_end && en);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state         <= c_IDLE;
         r_count         <= '0;
         r_div_active    <= c_def;
         r_pending       <= c_def;
         r_pending_valid <= 1'b0;
         r_sccb_clk      <= 1'b1;
         r_fall          <= 1'b0;
         r_rise          <= 1'b0;
         r_mid_low       <= 1'b0;
         r_mid_high      <= 1'b0;
         r_stop          <= 1'b0;
      end else begin
         r_fall     <= 1'b0;
         r_rise     <= 1'b0;
         r_stop     <= 1'b0;
         r_mid_low  <= (r_state == c_LOW)  && (r_count == w_mid);
         r_mid_high <= (r_state == c_HIGH) && (r_count == w_mid);

         if (w_boundary && r_pending_valid) begin
            r_div_active    <= r_pending;
            r_pending_valid <= 1'b0;
         end
         // a load coinciding with a boundary lands after the old pending was consumed
         if (div_load) begin
            r_pending       <= w_load_val;
            r_pending_valid <= 1'b1;
         end

         case (r_state)
            c_IDLE: begin
               r_count    <= '0;
               r_sccb_clk <= 1'b1;
               if (en) begin
                  r_state    <= c_LOW;
                  r_sccb_clk <= 1'b0;
                  r_fall     <= 1'b1;
               end
            end
            c_LOW: begin
               if (w_end) begin
                  r_state    <= c_HIGH;
                  r_count    <= '0;
                  r_sccb_clk <= 1'b1;
                  r_rise     <= 1'b1;
               end else begin
                  r_count <= r_count + DIV_WIDTH'(1);
               end
            end
            c_HIGH: begin
               if (w_end) begin
                  r_count <= '0;
                  if (en) begin
                     r_state    <= c_LOW;
                     r_sccb_clk <= 1'b0;
                     r_fall     <= 1'b1;
                  end else begin
                     r_state <= c_IDLE;
                     r_stop  <= 1'b1;
                  end
               end else begin
                  r_count <= r_count + DIV_WIDTH'(1);
               end
            end
            default: begin
               r_state    <= c_IDLE;
               r_count    <= '0;
               r_sccb_clk <= 1'b1;
            end
         endcase
      end
   end

   assign sccb_clk       = r_sccb_clk;
   assign fall_pulse     = r_fall;
   assign rise_pulse     = r_rise;
   assign mid_low_pulse  = r_mid_low;
   assign mid_high_pulse = r_mid_high;
   assign stop_pulse     = r_stop;
   assign busy           = (r_state != c_IDLE);
   assign div_active     = r_div_active;

endmodule
`default_nettype wire

// File: tb/tb_sccb_clk_gen.sv
`default_nettype none
// Bench for sccb_clk_gen: period-position reference model checked every cycle,
// plus directed timing checks on a D=4 instance and a default-parameter instance.
module tb_sccb_clk_gen;

   localparam int c_DW    = 16;
   localparam int c_DEF_A = 4;
   localparam int c_MIN   = 3;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            en = 1'b0;
   logic            div_load = 1'b0;
   logic [c_DW-1:0] div_in = '0;
   logic            sccb_clk, fall_pulse, rise_pulse, mid_low_pulse, mid_high_pulse;
   logic            stop_pulse, busy;
   logic [c_DW-1:0] div_active;

   logic            en_b = 1'b0;
   logic            sccb_clk_b, fall_b, rise_b, ml_b, mh_b, stop_b, busy_b;
   logic [c_DW-1:0] div_active_b;

   sccb_clk_gen #(.CLK_FREQ(1_000_000), .SCCB_CLK_FREQ(100_000), .DIV_WIDTH(c_DW), .DIV_MIN(c_MIN)) u_dut (
      .clk(clk), .resetn(resetn), .en(en), .div_in(div_in), .div_load(div_load),
      .sccb_clk(sccb_clk), .fall_pulse(fall_pulse), .rise_pulse(rise_pulse),
      .mid_low_pulse(mid_low_pulse), .mid_high_pulse(mid_high_pulse),
      .stop_pulse(stop_pulse), .busy(busy), .div_active(div_active));

   sccb_clk_gen u_dut_def (
      .clk(clk), .resetn(resetn), .en(en_b), .div_in('0), .div_load(1'b0),
      .sccb_clk(sccb_clk_b), .fall_pulse(fall_b), .rise_pulse(rise_b),
      .mid_low_pulse(ml_b), .mid_high_pulse(mh_b),
      .stop_pulse(stop_b), .busy(busy_b), .div_active(div_active_b));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_stop   = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (stop_pulse) n_stop <= n_stop + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: position p within the current period of length 2(d+1)
   bit m_run  = 1'b0;
   bit m_stop = 1'b0;
   bit m_pv   = 1'b0;
   int m_p    = 0;
   int m_d    = c_DEF_A;
   int m_pend = c_DEF_A;

   initial begin
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            m_run = 1'b0; m_stop = 1'b0; m_pv = 1'b0;
            m_p = 0; m_d = c_DEF_A; m_pend = c_DEF_A;
         end else begin
            automatic int  last     = 2 * (m_d + 1) - 1;
            automatic bit  boundary = !m_run || (m_p == last && en);
            m_stop = 1'b0;
            if (!m_run) begin
               if (en) begin m_run = 1'b1; m_p = 0; end
            end else if (m_p == last) begin
               if (en) m_p = 0;
               else begin m_run = 1'b0; m_stop = 1'b1; end
            end else begin
               m_p++;
            end
            if (boundary && m_pv) begin m_d = m_pend; m_pv = 1'b0; end
            if (div_load) begin
               m_pend = (int'(div_in) < c_MIN) ? c_MIN : int'(div_in);
               m_pv = 1'b1;
            end
         end
      end
   end

   function automatic logic [31:0] model_vec();
      automatic int h = m_d + 1;
      automatic int m = (m_d + 1) / 2 - 1;
      automatic logic [15:0] d16 = m_d[15:0];
      return {9'b0, (!m_run || m_p >= h), (m_run && m_p == 0), (m_run && m_p == h),
              (m_run && m_p == m + 1), (m_run && m_p == h + m + 1), m_stop, m_run, d16};
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         chk("cycle", {9'b0, sccb_clk, fall_pulse, rise_pulse, mid_low_pulse, mid_high_pulse,
                       stop_pulse, busy, div_active}, model_vec());
      end
   end

   function automatic logic pick(input int sel);
      case (sel)
         0: return fall_pulse;
         1: return mid_low_pulse;
         2: return rise_pulse;
         3: return mid_high_pulse;
         4: return stop_pulse;
         5: return fall_b;
         default: return ml_b;
      endcase
   endfunction

   task automatic wait_sig(input int sel, output int at);
      at = -1;
      for (int i = 0; i < 400 && at < 0; i++) begin
         @(negedge clk);
         if (pick(sel)) at = cyc;
      end
      if (at < 0) begin
         n_checks++;
         $display("FAIL timeout: signal %0d never pulsed, required within 400 cycles", sel);
      end
   endtask

   task automatic load(input logic [c_DW-1:0] v);
      div_in = v; div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
   endtask

   int t0, t1, t2, n0;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_clk", sccb_clk, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {fall_pulse, rise_pulse, mid_low_pulse, mid_high_pulse, stop_pulse}, 0);
      chk("rst_div", div_active, 4);
      chk("rst_div_def", div_active_b, 49);
      #2 resetn = 1'b1;

      // start latency and phase offsets, D=4
      @(negedge clk); en = 1'b1;
      @(negedge clk);
      chk("start_fall", fall_pulse, 1);
      chk("start_clk", sccb_clk, 0);
      t0 = cyc;
      wait_sig(1, t1); chk("mid_low_off", t1 - t0, 2);
      wait_sig(2, t1); chk("rise_off", t1 - t0, 5);
      wait_sig(3, t1); chk("mid_high_off", t1 - t0, 7);
      wait_sig(0, t1); chk("period4", t1 - t0, 10);

      // load 9 during LOW: current period unchanged, then 20-cycle periods
      load(16'd9);
      wait_sig(0, t2); chk("period_before_9", t2 - t1, 10);
      chk("div_9", div_active, 9);
      wait_sig(1, t0); chk("mid_low_9", t0 - t2, 5);
      wait_sig(0, t1); chk("period9", t1 - t2, 20);

      // load 1 clamps to 3
      load(16'd1);
      wait_sig(0, t2); chk("period_before_3", t2 - t1, 20);
      chk("div_clamp", div_active, 3);
      wait_sig(0, t1); chk("period3", t1 - t2, 8);

      // back to D=4, then drop en early in LOW
      load(16'd4);
      wait_sig(0, t2); chk("div_4", div_active, 4);
      en = 1'b0; n0 = n_stop;
      wait_sig(2, t0);
      wait_sig(4, t1); chk("stop_off", t1 - t0, 5);
      chk("stop_busy", busy, 0);
      chk("stop_clk", sccb_clk, 1);
      repeat (3) @(negedge clk);
      chk("idle_clk", sccb_clk, 1);
      chk("idle_busy", busy, 0);
      chk("stop_count", n_stop - n0, 1);

      // en re-asserted only in the last HIGH cycle: no idle visit
      en = 1'b1;
      wait_sig(0, t0);
      wait_sig(2, t1);
      en = 1'b0; n0 = n_stop;
      repeat (4) @(negedge clk);
      en = 1'b1;
      wait_sig(0, t2); chk("late_en_period", t2 - t0, 10);
      chk("late_en_nostop", n_stop - n0, 0);

      // reset in HIGH after loading 9
      load(16'd9);
      wait_sig(2, t0);
      #2 resetn = 1'b0;
      #1;
      chk("midrst_clk", sccb_clk, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_pulses", {fall_pulse, rise_pulse, mid_low_pulse, mid_high_pulse, stop_pulse}, 0);
      chk("midrst_div", div_active, 4);
      @(negedge clk);
      #2 resetn = 1'b1;
      wait_sig(0, t0);
      wait_sig(0, t1); chk("post_rst_period", t1 - t0, 10);
      chk("post_rst_div", div_active, 4);

      // default parameters: D=49
      @(negedge clk); en_b = 1'b1;
      wait_sig(5, t0);
      wait_sig(6, t1); chk("def_mid_low", t1 - t0, 25);
      wait_sig(5, t2); chk("def_period", t2 - t0, 100);
      chk("def_div", div_active_b, 49);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
